// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences one MAC lane through a dot-product job.
//   A start (with len) clears the MAC, streams len operand pairs into it
//   over a valid/ready handshake, then captures the accumulator and offers
//   it on a result handshake. abort cancels any job in flight.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, len, abort       job control (start/len sampled only in IDLE)
//   busy                    high whenever not IDLE
//   in_valid/in_ready       operand handshake, in_a/in_b operands
//   mac_en, mac_clr         MAC enable / clear
//   mac_a, mac_b            operand pass-through to the MAC
//   mac_cout                MAC accumulator output
//   res_valid/res_ready     result handshake, res_data captured result
module mac_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [LEN_WIDTH-1:0]      len,
   input  logic                      abort,
   output logic                      busy,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_a,
   input  logic [DATA_WIDTH-1:0]     in_b,
   output logic                      mac_en,
   output logic                      mac_clr,
   output logic [DATA_WIDTH-1:0]     mac_a,
   output logic [DATA_WIDTH-1:0]     mac_b,
   input  logic [3*DATA_WIDTH-1:0]   mac_cout,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [3*DATA_WIDTH-1:0]   res_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACCUM,
      S_CAPTURE,
      S_RESULT
   } state_e;

   state_e                    state_q, state_d;
   logic [LEN_WIDTH-1:0]      remaining_q, remaining_d;
   logic                      res_valid_q, res_valid_d;
   logic [3*DATA_WIDTH-1:0]   res_data_q, res_data_d;

   // Operands go straight to the MAC so it accumulates on the accepting edge.
   assign mac_a     = in_a;
   assign mac_b     = in_b;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      busy        = (state_q != S_IDLE);
      in_ready    = 1'b0;
      mac_en      = 1'b0;
      mac_clr     = 1'b0;

      if (abort) begin
         // Abort outranks everything; in IDLE it only suppresses a start.
         if (state_q != S_IDLE) begin
            state_d     = S_IDLE;
            remaining_d = '0;
            res_valid_d = 1'b0;
            mac_clr     = 1'b1;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  remaining_d = len;
                  state_d     = S_CLEAR;
               end
            end
            S_CLEAR: begin
               mac_clr = 1'b1;
               state_d = (remaining_q != '0) ? S_ACCUM : S_CAPTURE;
            end
            S_ACCUM: begin
               in_ready = 1'b1;
               mac_en   = in_valid;
               if (in_valid) begin
                  remaining_d = remaining_q - LEN_WIDTH'(1);
                  if (remaining_q == LEN_WIDTH'(1)) begin
                     state_d = S_CAPTURE;
                  end
               end
            end
            S_CAPTURE: begin
               res_data_d  = mac_cout;
               res_valid_d = 1'b1;
               state_d     = S_RESULT;
            end
            S_RESULT: begin
               if (res_ready) begin
                  res_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;

   localparam int DW = 8;
   localparam int LW = 9;
   localparam int RW = 3 * DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [LW-1:0] len;
   logic          abort;
   logic          busy;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_a, in_b;
   logic          mac_en, mac_clr;
   logic [DW-1:0] mac_a, mac_b;
   logic [RW-1:0] mac_cout;
   logic          res_valid;
   logic          res_ready;
   logic [RW-1:0] res_data;

   int vectors     = 0;
   int miscompares = 0;
   int en_cnt      = 0;
   int clr_cnt     = 0;
   int rdy_cnt     = 0;
   int qa[$];
   int qb[$];

   always #5 clk = ~clk;

   mac_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
      .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .mac_en(mac_en), .mac_clr(mac_clr),
      .mac_a(mac_a), .mac_b(mac_b), .mac_cout(mac_cout),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   // Behavioural MAC unit the sequencer drives.
   logic [RW-1:0] acc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)       acc <= '0;
      else if (mac_clr) acc <= '0;
      else if (mac_en)  acc <= acc + mac_a * mac_b;
   end
   assign mac_cout = acc;

   // Per-cycle pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         en_cnt  += int'(mac_en);
         clr_cnt += int'(mac_clr);
         rdy_cnt += int'(in_ready);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   task automatic fill_rand(input int n);
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin
         qa.push_back(int'($urandom_range(0, 255)));
         qb.push_back(int'($urandom_range(0, 255)));
      end
   endtask

   // Entered at posedge+1 with the DUT idle; leaves at posedge+1, idle.
   // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random bubbles.
   task automatic run_job(input int n, input int gap_mode, input int rr_delay, input bit start_in_result);
      longint exp_sum = 0;
      int en0 = en_cnt, clr0 = clr_cnt, rdy0 = rdy_cnt;
      int sent = 0, cyc = 0;
      for (int i = 0; i < n; i++) exp_sum += longint'(qa[i]) * longint'(qb[i]);
      exp_sum = exp_sum & ((longint'(1) << RW) - 1);

      start = 1'b1; len = LW'(n);
      @(posedge clk); #1;
      start = 1'b0; len = '0;
      @(negedge clk);
      check_eq("clear_pulse", 64'(mac_clr), 64'd1);
      check_eq("clear_no_ready", 64'(in_ready), 64'd0);
      check_eq("clear_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;

      while (sent < n && cyc < 4 * n + 20) begin
         case (gap_mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (cyc % 2 == 1);
            default: in_valid = ($urandom_range(0, 2) != 0);
         endcase
         in_a = DW'(qa[sent]); in_b = DW'(qb[sent]);
         @(negedge clk);
         if (cyc == 0) check_eq("ready_after_clear", 64'(in_ready), 64'd1);
         if (in_valid && in_ready) begin
            check_eq("mac_a_pass", 64'(mac_a), 64'(qa[sent]));
            check_eq("mac_b_pass", 64'(mac_b), 64'(qb[sent]));
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (sent < n) check_eq("beat_timeout", 64'(sent), 64'(n));

      // Capture cycle: offer a junk beat that must not be consumed.
      in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55;
      @(negedge clk);
      check_eq("capture_no_valid", 64'(res_valid), 64'd0);
      check_eq("capture_no_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("res_valid_rise", 64'(res_valid), 64'd1);
      check_eq("res_data", 64'(res_data), 64'(exp_sum));

      for (int k = 0; k < rr_delay; k++) begin
         @(posedge clk); #1;
         start = start_in_result && (k == 1);
         len = LW'(7);
         @(negedge clk);
         check_eq("hold_valid", 64'(res_valid), 64'd1);
         check_eq("hold_data", 64'(res_data), 64'(exp_sum));
         check_eq("hold_busy", 64'(busy), 64'd1);
         start = 1'b0;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      check_eq("done_valid", 64'(res_valid), 64'd0);
      check_eq("done_idle", 64'(busy), 64'd0);
      check_eq("beat_count", 64'(en_cnt - en0), 64'(n));
      check_eq("clear_count", 64'(clr_cnt - clr0), 64'd1);
      if (n == 0) check_eq("len0_never_ready", 64'(rdy_cnt - rdy0), 64'd0);
      if (gap_mode == 0) check_eq("ready_cycles", 64'(rdy_cnt - rdy0), 64'(n));
      @(posedge clk); #1;
   endtask

   initial begin
      int en0, clr0;
      rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_ready", 64'(in_ready), 64'd0);
      check_eq("rst_en", 64'(mac_en), 64'd0);
      check_eq("rst_clr", 64'(mac_clr), 64'd0);
      check_eq("rst_res_valid", 64'(res_valid), 64'd0);
      check_eq("rst_res_data", 64'(res_data), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic job: expected 1*2+3*4+5*6+7*8 = 100.
      qa = '{1, 3, 5, 7}; qb = '{2, 4, 6, 8};
      run_job(4, 0, 0, 1'b0);

      // Gapped stream of max operands: 3*65025 = 195075.
      qa = '{255, 255, 255}; qb = '{255, 255, 255};
      run_job(3, 1, 0, 1'b0);

      // Zero-length job.
      qa.delete(); qb.delete();
      run_job(0, 0, 0, 1'b0);

      // Result backpressure with a stray start during RESULT.
      fill_rand(5);
      run_job(5, 0, 5, 1'b1);

      // Abort after 2 of 4 beats.
      fill_rand(4);
      en0 = en_cnt; clr0 = clr_cnt;
      start = 1'b1; len = LW'(4);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_a = DW'(qa[i]); in_b = DW'(qb[i]);
         @(posedge clk); #1;
      end
      abort = 1'b1;
      @(negedge clk);
      check_eq("abort_clr", 64'(mac_clr), 64'd1);
      check_eq("abort_no_ready", 64'(in_ready), 64'd0);
      check_eq("abort_no_en", 64'(mac_en), 64'd0);
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check_eq("abort_idle", 64'(busy), 64'd0);
      check_eq("abort_res_valid", 64'(res_valid), 64'd0);
      check_eq("abort_beats", 64'(en_cnt - en0), 64'd2);
      check_eq("abort_clears", 64'(clr_cnt - clr0), 64'd2);
      @(posedge clk); #1;
      qa = '{2}; qb = '{3};
      run_job(1, 0, 0, 1'b0);

      // abort together with start in IDLE: no job starts.
      start = 1'b1; abort = 1'b1; len = LW'(3);
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check_eq("abort_start_idle", 64'(busy), 64'd0);
      check_eq("abort_start_no_clr", 64'(mac_clr), 64'd0);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a job.
      start = 1'b1; len = LW'(8);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_busy", 64'(busy), 64'd0);
      check_eq("async_rst_ready", 64'(in_ready), 64'd0);
      check_eq("async_rst_en", 64'(mac_en), 64'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      qa = '{4, 5}; qb = '{6, 7};
      run_job(2, 0, 0, 1'b0);

      // Long job of max operands: (257*65025) mod 2^24.
      qa.delete(); qb.delete();
      for (int i = 0; i < 257; i++) begin
         qa.push_back(255); qb.push_back(255);
      end
      run_job(257, 0, 0, 1'b0);

      // Randomized jobs with random bubbles and backpressure.
      for (int j = 0; j < 12; j++) begin
         int n;
         n = int'($urandom_range(1, 24));
         fill_rand(n);
         run_job(n, 2, int'($urandom_range(0, 3)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
